// File: rtl/sqrt_core.sv
// Radix-2 restoring square-root datapath: one root bit per cycle, truncated result plus metadata.
// Optional macro SQRT_ZERO_BYPASS_EN: a zero radicand finishes one cycle after start.
module sqrt_core #(
    parameter int IN_M_SIZE  = 106,
    parameter int OUT_M_SIZE = 53,
    parameter int EXP_SIZE   = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_M_SIZE-1:0]  in_mantisa,
    input  logic [EXP_SIZE-1:0]   in_exp,
    input  logic [2:0]            in_flags,
    input  logic                  in_type,
    input  logic                  sign,
    output logic [OUT_M_SIZE-1:0] out_mantisa,
    output logic [EXP_SIZE-1:0]   out_exp,
    output logic [2:0]            out_flags,
    output logic                  out_type,
    output logic                  busy,
    output logic                  done
);
    localparam int CNT_W = $clog2(OUT_M_SIZE);
    localparam int RW    = OUT_M_SIZE + 2;
    localparam int TW    = OUT_M_SIZE + 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_reg;
    logic [IN_M_SIZE-1:0]  rad_reg;
    logic [OUT_M_SIZE-1:0] q_reg;
    logic [RW-1:0]         r_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [EXP_SIZE-1:0]   exp_reg;
    logic [2:0]            flags_reg;
    logic                  type_reg;
    logic                  short_reg;
    logic                  neg_reg;

    logic [TW-1:0]         r_shift;
    logic [TW-1:0]         t_val;
    logic [RW-1:0]         r_next;
    logic [OUT_M_SIZE-1:0] q_next;
    logic                  start_neg;
    logic                  start_bypass;

    assign start_neg = sign && (in_mantisa != '0);
`ifdef SQRT_ZERO_BYPASS_EN
    assign start_bypass = (in_mantisa == '0);
`else
    assign start_bypass = 1'b0;
`endif

    // The remainder never exceeds 2Q+1, so its top bit is always zero before the shift;
    // the extra MSB of t_val acts as the borrow.
    always_comb begin
        r_shift = {1'b0, r_reg[RW-2:0], rad_reg[IN_M_SIZE-1 -: 2]};
        t_val   = r_shift - {2'b00, q_reg, 2'b01};
        if (t_val[TW-1]) begin
            r_next = r_shift[RW-1:0];
            q_next = {q_reg[OUT_M_SIZE-2:0], 1'b0};
        end else begin
            r_next = t_val[RW-1:0];
            q_next = {q_reg[OUT_M_SIZE-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rad_reg     <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            cnt_reg     <= '0;
            exp_reg     <= '0;
            flags_reg   <= '0;
            type_reg    <= 1'b0;
            short_reg   <= 1'b0;
            neg_reg     <= 1'b0;
            out_mantisa <= '0;
            out_exp     <= '0;
            out_flags   <= '0;
            out_type    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rad_reg   <= in_mantisa;
                        exp_reg   <= in_exp;
                        flags_reg <= in_flags;
                        type_reg  <= in_type;
                        neg_reg   <= start_neg;
                        short_reg <= start_neg | start_bypass;
                        q_reg     <= '0;
                        r_reg     <= '0;
                        cnt_reg   <= CNT_W'(OUT_M_SIZE - 1);
                        busy      <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    if (short_reg) begin
                        // Negative operand (NaN-style all-ones root) or bypassed zero.
                        out_mantisa <= neg_reg ? '1 : '0;
                        out_flags   <= neg_reg ? {flags_reg[2], 1'b1, flags_reg[0]} : flags_reg;
                        out_exp     <= exp_reg;
                        out_type    <= type_reg;
                        done        <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        rad_reg <= rad_reg << 2;
                        q_reg   <= q_next;
                        r_reg   <= r_next;
                        cnt_reg <= cnt_reg - CNT_W'(1);
                        if (cnt_reg == '0) begin
                            out_mantisa <= q_next;
                            out_flags   <= {flags_reg[2], flags_reg[1], flags_reg[0] | (r_next != '0)};
                            out_exp     <= exp_reg;
                            out_type    <= type_reg;
                            done        <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_core.sv
// Directed vector bench for sqrt_core: table of radicands with hand-computed roots, plus
// sequences for ignored start, mid-operation reset and output hold.
module tb_sqrt_core;
    localparam int IM = 106;
    localparam int OM = 53;
    localparam int EW = 11;
`ifdef SQRT_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 53;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IM-1:0] in_mantisa = '0;
    logic [EW-1:0] in_exp = '0;
    logic [2:0]    in_flags = '0;
    logic          in_type = 1'b0;
    logic          sign = 1'b0;
    logic [OM-1:0] out_mantisa;
    logic [EW-1:0] out_exp;
    logic [2:0]    out_flags;
    logic          out_type;
    logic          busy;
    logic          done;

    sqrt_core #(.IN_M_SIZE(IM), .OUT_M_SIZE(OM), .EXP_SIZE(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_mantisa(in_mantisa), .in_exp(in_exp),
        .in_flags(in_flags), .in_type(in_type), .sign(sign), .out_mantisa(out_mantisa),
        .out_exp(out_exp), .out_flags(out_flags), .out_type(out_type), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [IM-1:0] mant;
        logic [EW-1:0] exp;
        logic [2:0]    flags;
        logic          typ;
        logic          sgn;
        logic [OM-1:0] root;
        logic [2:0]    rflags;
        int            lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic launch(input logic [IM-1:0] m, input logic [EW-1:0] e, input logic [2:0] f,
                          input logic t, input logic s);
        in_mantisa = m;
        in_exp     = e;
        in_flags   = f;
        in_type    = t;
        sign       = s;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 200);
    endtask

    task automatic run_vec(input int i);
        int cyc;
        launch(vecs[i].mant, vecs[i].exp, vecs[i].flags, vecs[i].typ, vecs[i].sgn);
        check($sformatf("v%0d_busy_start", i), 64'(busy), 64'd1);
        wait_done(cyc);
        check($sformatf("v%0d_latency", i), 64'(cyc), 64'(vecs[i].lat));
        check($sformatf("v%0d_root", i), 64'(out_mantisa), 64'(vecs[i].root));
        check($sformatf("v%0d_flags", i), 64'(out_flags), 64'(vecs[i].rflags));
        check($sformatf("v%0d_exp", i), 64'(out_exp), 64'(vecs[i].exp));
        check($sformatf("v%0d_type", i), 64'(out_type), 64'(vecs[i].typ));
        check($sformatf("v%0d_busy_done", i), 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_done_width", i), 64'(done), 64'd0);
        check($sformatf("v%0d_busy_end", i), 64'(busy), 64'd0);
        $display("vec %0d: mant=%0h sign=%0b root=%0h flags=%03b latency=%0d",
                 i, vecs[i].mant, vecs[i].sgn, out_mantisa, out_flags, cyc);
    endtask

    initial begin
        int pulses;
        int first;
        logic [OM-1:0] root_at;
        logic [OM-1:0] ones;
        ones = '1;

        vecs[0]  = '{(106'd1 << 104), 11'h000, 3'b100, 1'b0, 1'b0, (53'd1 << 52), 3'b100, 53};
        vecs[1]  = '{(106'd1 << 105), 11'h400, 3'b000, 1'b0, 1'b0, 53'h16A09E667F3BCC, 3'b001, 53};
        vecs[2]  = '{106'd9, 11'h3FF, 3'b000, 1'b1, 1'b0, 53'd3, 3'b000, 53};
        vecs[3]  = '{((106'd1 << 105) - 106'd1) | (106'd1 << 105), 11'h7FF, 3'b010, 1'b0, 1'b0,
                     ones, 3'b011, 53};
        vecs[4]  = '{106'd1, 11'h001, 3'b000, 1'b0, 1'b0, 53'd1, 3'b000, 53};
        vecs[5]  = '{106'd2, 11'h002, 3'b000, 1'b1, 1'b0, 53'd1, 3'b001, 53};
        vecs[6]  = '{106'd144, 11'h123, 3'b100, 1'b0, 1'b0, 53'd12, 3'b100, 53};
        vecs[7]  = '{106'd15, 11'h055, 3'b000, 1'b0, 1'b0, 53'd3, 3'b001, 53};
        vecs[8]  = '{106'd0, 11'h3AA, 3'b100, 1'b1, 1'b0, 53'd0, 3'b100, ZLAT};
        vecs[9]  = '{106'd0, 11'h011, 3'b000, 1'b0, 1'b1, 53'd0, 3'b000, ZLAT};
        vecs[10] = '{106'd5, 11'h222, 3'b001, 1'b0, 1'b1, ones, 3'b011, 1};
        vecs[11] = '{(106'd1 << 105), 11'h333, 3'b100, 1'b1, 1'b1, ones, 3'b110, 1};
        // (2^52+1)^2 = 2^104 + 2^53 + 1, exact; one less truncates to 2^52.
        vecs[12] = '{(106'd1 << 104) + (106'd1 << 53) + 106'd1, 11'h444, 3'b000, 1'b0, 1'b0,
                     (53'd1 << 52) + 53'd1, 3'b000, 53};
        vecs[13] = '{(106'd1 << 104) + (106'd1 << 53), 11'h555, 3'b000, 1'b1, 1'b0,
                     (53'd1 << 52), 3'b001, 53};

        repeat (2) @(posedge clk);
        #1;
        check("reset_root", 64'(out_mantisa), 64'd0);
        check("reset_flags", 64'(out_flags), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) run_vec(i);

        repeat (5) @(posedge clk);
        #1;
        check("hold_root", 64'(out_mantisa), 64'(vecs[13].root));
        check("hold_flags", 64'(out_flags), 64'(vecs[13].rflags));

        // Second start at edge 20 of an operation must be ignored.
        launch(vecs[0].mant, 11'h0AB, 3'b100, 1'b0, 1'b0);
        pulses = 0;
        first = 0;
        root_at = '0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 20) begin
                in_mantisa = 106'd9;
                in_exp     = 11'h3FF;
                in_flags   = 3'b011;
                in_type    = 1'b1;
                start      = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    root_at = out_mantisa;
                end
            end
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_latency", 64'(first), 64'd53);
        check("ignore_root", 64'(root_at), 64'(vecs[0].root));
        check("ignore_exp", 64'(out_exp), 64'h0AB);
        check("ignore_flags", 64'(out_flags), 64'b100);
        $display("seq ignore_start: pulses=%0d latency=%0d root=%0h", pulses, first, root_at);

        // Asynchronous reset at cycle 30 of an operation.
        launch(vecs[1].mant, 11'h400, 3'b010, 1'b1, 1'b0);
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #2;
        check("rst_root", 64'(out_mantisa), 64'd0);
        check("rst_exp", 64'(out_exp), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("rst_no_done", 64'(pulses), 64'd0);
        check("rst_idle", 64'(busy), 64'd0);
        $display("seq mid_reset: done_pulses_after=%0d", pulses);
        run_vec(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
